// File: rtl/reg_serial_reader_if.sv
// Handshake bundle between a register-reader requester and reg_serial_reader.
// master: requester/serial consumer side; slave: reg_serial_reader.
interface reg_serial_reader_if #(
  parameter int size = 8
);
  logic            startRd;
  logic [size-1:0] dataInrd;
  logic            serReady;
  logic            serOut;
  logic            serValid;
  logic            serLast;
  logic            busyRd;
  logic            doneRd;

  modport master (
    output startRd, dataInrd, serReady,
    input  serOut, serValid, serLast, busyRd, doneRd
  );

  modport slave (
    input  startRd, dataInrd, serReady,
    output serOut, serValid, serLast, busyRd, doneRd
  );
endinterface

// File: rtl/reg_serial_reader.sv
// Snapshots a register value and streams it MSB first over valid/ready.
// Optional REG_SERIAL_READER_PARITY_EN appends an even-parity bit after the LSB.
module reg_serial_reader #(
  parameter int size = 8,
  parameter int CNTW = 4
) (
  input  logic               clk,
  input  logic               rstn,
  reg_serial_reader_if.slave bus
);

`ifdef REG_SERIAL_READER_PARITY_EN
  localparam int W = size + 1;
`else
  localparam int W = size;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    shift_q, shift_nxt;
  logic [CNTW-1:0] cnt_q, cnt_nxt;
  logic [W-1:0]    cap_word;
  logic [CNTW-1:0] cnt_init;

`ifdef REG_SERIAL_READER_PARITY_EN
  assign cap_word = {bus.dataInrd, ^bus.dataInrd};
  assign cnt_init = CNTW'(size);
`else
  assign cap_word = bus.dataInrd;
  assign cnt_init = CNTW'(size - 1);
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state   <= state_nxt;
      shift_q <= shift_nxt;
      cnt_q   <= cnt_nxt;
    end
  end

  // Outputs decode from state/shift/cnt only, so serReady never reaches them.
  always_comb begin
    state_nxt    = state;
    shift_nxt    = shift_q;
    cnt_nxt      = cnt_q;
    bus.serOut   = shift_q[W-1];
    bus.serValid = 1'b0;
    bus.serLast  = 1'b0;
    bus.busyRd   = 1'b0;
    bus.doneRd   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.startRd) begin
          shift_nxt = cap_word;
          cnt_nxt   = cnt_init;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        bus.serValid = 1'b1;
        bus.busyRd   = 1'b1;
        bus.serLast  = (cnt_q == '0);
        if (bus.serReady) begin
          shift_nxt = {shift_q[W-2:0], 1'b0};
          if (cnt_q == '0) state_nxt = DONE;
          else             cnt_nxt   = cnt_q - CNTW'(1);
        end
      end
      DONE: begin
        bus.busyRd = 1'b1;
        bus.doneRd = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_reg_serial_reader.sv
// Directed bench for reg_serial_reader: frames, stalls, isolation, reset abort, back-to-back.
module tb_reg_serial_reader;
  localparam int SIZE = 8;
`ifdef REG_SERIAL_READER_PARITY_EN
  localparam int FR = SIZE + 1;
`else
  localparam int FR = SIZE;
`endif

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  reg_serial_reader_if #(.size(SIZE)) bus();

  reg_serial_reader #(.size(SIZE), .CNTW(4)) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Expected frame: the byte, plus an even-parity bit when that feature is built in.
  function automatic logic [15:0] exp_frame(input logic [7:0] d);
`ifdef REG_SERIAL_READER_PARITY_EN
    return {7'b0, d, ^d};
`else
    return {8'b0, d};
`endif
  endfunction

  // Runs one frame as the consumer; gathers observations, no judgement.
  task automatic collect(input bit drop_start, input int stall_after, input int stall_len,
                         output logic [15:0] bits, output int nbits, output int last_idx,
                         output int last_cnt, output int ndone, output int ncyc,
                         output bit hold_ok, output bit tmo);
    bit   started = 1'b0;
    int   stalled = 0;
    logic held    = 1'b0;
    bits = '0; nbits = 0; last_idx = 0; last_cnt = 0; ndone = 0; ncyc = 0;
    hold_ok = 1'b1; tmo = 1'b1;
    bus.serReady = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(posedge clk); #1;
      ncyc++;
      if (c == 0 && drop_start) bus.startRd = 1'b0;
      if (bus.doneRd) ndone++;
      if (!bus.busyRd && started) begin
        tmo = 1'b0;
        break;
      end
      if (bus.busyRd) started = 1'b1;
      if (bus.serValid) begin
        if (nbits == stall_after && stalled < stall_len) begin
          if (stalled == 0) held = bus.serOut;
          else if (bus.serOut !== held) hold_ok = 1'b0;
          stalled++;
          bus.serReady = 1'b0;
        end else begin
          if (stalled > 0 && nbits == stall_after && bus.serOut !== held) hold_ok = 1'b0;
          bus.serReady = 1'b1;
          bits = {bits[14:0], bus.serOut};
          nbits++;
          if (bus.serLast) begin
            last_cnt++;
            last_idx = nbits;
          end
        end
      end else begin
        bus.serReady = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    checks++; if (bus.serOut !== 1'b0)   begin errors++; $display("FAIL reset_serOut got %b want 0", bus.serOut); end
    checks++; if (bus.serValid !== 1'b0) begin errors++; $display("FAIL reset_serValid got %b want 0", bus.serValid); end
    checks++; if (bus.serLast !== 1'b0)  begin errors++; $display("FAIL reset_serLast got %b want 0", bus.serLast); end
    checks++; if (bus.busyRd !== 1'b0)   begin errors++; $display("FAIL reset_busyRd got %b want 0", bus.busyRd); end
    checks++; if (bus.doneRd !== 1'b0)   begin errors++; $display("FAIL reset_doneRd got %b want 0", bus.doneRd); end
    @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.busyRd !== 1'b0) begin errors++; $display("FAIL idle_busyRd got %b want 0", bus.busyRd); end
  endtask

  task automatic test_basic();
    logic [15:0] bits; int nb, li, lc, nd, nc; bit ho, to;
    bus.dataInrd = 8'hA5; bus.startRd = 1'b1;
    collect(1'b1, -1, 0, bits, nb, li, lc, nd, nc, ho, to);
    checks++; if (to)                       begin errors++; $display("FAIL basic_timeout got 1 want 0"); end
    checks++; if (nb != FR)                 begin errors++; $display("FAIL basic_nbits got %0d want %0d", nb, FR); end
    checks++; if (bits !== exp_frame(8'hA5)) begin errors++; $display("FAIL basic_bits got %h want %h", bits, exp_frame(8'hA5)); end
    checks++; if (lc != 1 || li != FR)      begin errors++; $display("FAIL basic_last got cnt %0d idx %0d want 1/%0d", lc, li, FR); end
    checks++; if (nd != 1)                  begin errors++; $display("FAIL basic_done got %0d want 1", nd); end
    checks++; if (nc != FR + 2)             begin errors++; $display("FAIL basic_cycles got %0d want %0d", nc, FR + 2); end
    checks++; if (bus.busyRd !== 1'b0)      begin errors++; $display("FAIL basic_busy_end got %b want 0", bus.busyRd); end
  endtask

  task automatic test_stall();
    logic [15:0] bits; int nb, li, lc, nd, nc; bit ho, to;
    bus.dataInrd = 8'h3C; bus.startRd = 1'b1;
    collect(1'b1, 2, 3, bits, nb, li, lc, nd, nc, ho, to);
    checks++; if (to || nb != FR)            begin errors++; $display("FAIL stall_nbits got %0d want %0d", nb, FR); end
    checks++; if (bits !== exp_frame(8'h3C)) begin errors++; $display("FAIL stall_bits got %h want %h", bits, exp_frame(8'h3C)); end
    checks++; if (!ho)                       begin errors++; $display("FAIL stall_hold got 0 want 1"); end
    checks++; if (nc != FR + 5)              begin errors++; $display("FAIL stall_cycles got %0d want %0d", nc, FR + 5); end
    checks++; if (nd != 1)                   begin errors++; $display("FAIL stall_done got %0d want 1", nd); end
  endtask

  task automatic test_isolation();
    logic [15:0] bits; int nb, li, lc, nd, nc; bit ho, to; int bz;
    bus.dataInrd = 8'h3C; bus.startRd = 1'b1;
    fork
      collect(1'b1, -1, 0, bits, nb, li, lc, nd, nc, ho, to);
      begin
        @(posedge clk);
        @(posedge clk); #2 bus.dataInrd = 8'hFF;
        @(posedge clk); #2 bus.startRd  = 1'b1;
        @(posedge clk); #2 bus.startRd  = 1'b0;
      end
    join
    checks++; if (to || bits !== exp_frame(8'h3C)) begin errors++; $display("FAIL iso_bits got %h want %h", bits, exp_frame(8'h3C)); end
    checks++; if (nd != 1)                         begin errors++; $display("FAIL iso_done got %0d want 1", nd); end
    bz = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.busyRd) bz++;
    end
    checks++; if (bz != 0) begin errors++; $display("FAIL iso_no_requeue got %0d want 0", bz); end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] bits; int nb, li, lc, nd, nc; bit ho, to; int dn;
    bus.dataInrd = 8'hA5; bus.startRd = 1'b1; bus.serReady = 1'b1;
    @(posedge clk); #1 bus.startRd = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (bus.serValid !== 1'b1) begin errors++; $display("FAIL mid_prevalid got %b want 1", bus.serValid); end
    #2 rstn = 1'b0;
    #1;
    checks++; if (bus.serValid !== 1'b0) begin errors++; $display("FAIL mid_serValid got %b want 0", bus.serValid); end
    checks++; if (bus.busyRd !== 1'b0)   begin errors++; $display("FAIL mid_busyRd got %b want 0", bus.busyRd); end
    checks++; if (bus.serOut !== 1'b0)   begin errors++; $display("FAIL mid_serOut got %b want 0", bus.serOut); end
    dn = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (bus.doneRd) dn++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL mid_no_done got %0d want 0", dn); end
    rstn = 1'b1;
    bus.dataInrd = 8'h81; bus.startRd = 1'b1;
    collect(1'b1, -1, 0, bits, nb, li, lc, nd, nc, ho, to);
    checks++; if (to || bits !== exp_frame(8'h81)) begin errors++; $display("FAIL post_reset_bits got %h want %h", bits, exp_frame(8'h81)); end
    checks++; if (nd != 1)                         begin errors++; $display("FAIL post_reset_done got %0d want 1", nd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] b1, b2; int nb, li, lc, nd1, nd2, nc1, nc2; bit ho, to1, to2;
    bus.dataInrd = 8'hF0; bus.startRd = 1'b1;
    fork
      collect(1'b0, -1, 0, b1, nb, li, lc, nd1, nc1, ho, to1);
      begin @(posedge clk); #2 bus.dataInrd = 8'h0F; end
    join
    collect(1'b0, -1, 0, b2, nb, li, lc, nd2, nc2, ho, to2);
    bus.startRd = 1'b0;
    checks++; if (to1 || b1 !== exp_frame(8'hF0)) begin errors++; $display("FAIL b2b_frame1 got %h want %h", b1, exp_frame(8'hF0)); end
    checks++; if (to2 || b2 !== exp_frame(8'h0F)) begin errors++; $display("FAIL b2b_frame2 got %h want %h", b2, exp_frame(8'h0F)); end
    checks++; if (nc1 != FR + 2 || nc2 != FR + 2) begin errors++; $display("FAIL b2b_spacing got %0d/%0d want %0d", nc1, nc2, FR + 2); end
    checks++; if (nd1 != 1 || nd2 != 1)           begin errors++; $display("FAIL b2b_done got %0d/%0d want 1/1", nd1, nd2); end
  endtask

`ifdef REG_SERIAL_READER_PARITY_EN
  task automatic test_parity();
    logic [15:0] bits; int nb, li, lc, nd, nc; bit ho, to;
    repeat (2) @(posedge clk); #1;
    bus.dataInrd = 8'hA5; bus.startRd = 1'b1;
    collect(1'b1, -1, 0, bits, nb, li, lc, nd, nc, ho, to);
    checks++; if (to || nb != 9 || bits !== 16'h014A) begin errors++; $display("FAIL par_a5 got %h n %0d want 014a n 9", bits, nb); end
    checks++; if (li != 9 || lc != 1)                  begin errors++; $display("FAIL par_last got idx %0d cnt %0d want 9/1", li, lc); end
    bus.dataInrd = 8'h07; bus.startRd = 1'b1;
    collect(1'b1, -1, 0, bits, nb, li, lc, nd, nc, ho, to);
    checks++; if (to || bits !== 16'h000F)             begin errors++; $display("FAIL par_07 got %h want 000f", bits); end
  endtask
`endif

  initial begin
    bus.startRd = 1'b0; bus.dataInrd = '0; bus.serReady = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_isolation();
    test_reset_midframe();
    test_back_to_back();
`ifdef REG_SERIAL_READER_PARITY_EN
    test_parity();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end
endmodule
